// File: rtl/dsm_sample_scheduler.sv
// Sample scheduler for the first-order DSM DAC: buffers PCM samples in a small FIFO
// and hands one to the modulator every r_osr clocks, with start / stop / drain control.
module dsm_sample_scheduler #(
    parameter int DATA_WIDTH = 16,
    parameter int FIFO_DEPTH = 4,
    parameter int OSR_WIDTH  = 16
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic                  i_start,
    input  logic                  i_stop,
    input  logic [OSR_WIDTH-1:0]  i_osr,
    input  logic                  i_s_valid,
    output logic                  o_s_ready,
    input  logic [DATA_WIDTH-1:0] i_s_data,
    output logic                  o_dac_en,
    output logic [DATA_WIDTH-1:0] o_dac_data,
    output logic                  o_sample_tick,
    output logic                  o_underflow,
    output logic                  o_busy
);

    localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

    typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

    state_t                state;
    state_t                state_nxt;
    logic [AW-1:0]         wr_ptr;
    logic [AW-1:0]         rd_ptr;
    logic [AW:0]           count;
    logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];
    logic [OSR_WIDTH-1:0]  r_osr;
    logic [OSR_WIDTH-1:0]  div;
    logic [OSR_WIDTH-1:0]  osr_clamped;
    logic                  start_go;
    logic                  tick;
    logic                  fifo_empty;
    logic                  fifo_full;
    logic                  push;
    logic                  pop;

    // The start edge itself is a tick, so the first sample reaches the modulator at once.
    assign start_go    = (state == IDLE) && i_start && !i_stop;
    assign tick        = start_go || ((state != IDLE) && (div == r_osr - OSR_WIDTH'(1)));
    assign fifo_empty  = (count == '0);
    assign fifo_full   = (count == (AW+1)'(FIFO_DEPTH));
    assign push        = i_s_valid && o_s_ready;
    assign pop         = tick && !fifo_empty;
    assign osr_clamped = (i_osr < OSR_WIDTH'(2)) ? OSR_WIDTH'(2) : i_osr;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start_go) state_nxt = RUN;
            RUN:     if (i_stop) state_nxt = DRAIN;
            DRAIN:   if (tick && fifo_empty) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        o_s_ready = !fifo_full && (state != DRAIN);
        o_dac_en  = (state != IDLE);
        o_busy    = (state != IDLE);
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({push, pop})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge i_clk) begin
        if (push) mem[wr_ptr] <= i_s_data;
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_osr <= OSR_WIDTH'(2);
            div   <= '0;
        end else if (start_go) begin
            r_osr <= osr_clamped;
            div   <= '0;
        end else if (state != IDLE) begin
            div <= tick ? '0 : div + OSR_WIDTH'(1);
        end
    end

    // An empty FIFO at a tick is an underflow in RUN, but the end of playback in DRAIN.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_dac_data    <= '0;
            o_sample_tick <= 1'b0;
            o_underflow   <= 1'b0;
        end else begin
            o_sample_tick <= 1'b0;
            if (start_go) o_underflow <= 1'b0;
            if (tick) begin
                if (!fifo_empty) begin
                    o_dac_data    <= mem[rd_ptr];
                    o_sample_tick <= 1'b1;
                end else if (state == DRAIN) begin
                    o_dac_data <= '0;
                end else begin
                    o_underflow   <= 1'b1;
                    o_sample_tick <= 1'b1;
                end
            end
        end
    end

endmodule

// File: doc/dsm_sample_scheduler.md
Name: dsm_sample_scheduler

Overview:
- Sequences the first-order DSM DAC: buffers incoming PCM samples in a small FIFO and presents one sample to the modulator every OSR clocks.
- Drives the modulator enable and handles start, stop and drain.
- Flags underflow when no sample is available at a sample boundary.
- Sits between the sample source (input FSM or stream) and dsm_dac: o_dac_en goes to dsm_dac i_en, o_dac_data goes to dsm_dac i_data.

Parameters:
- DATA_WIDTH, 16, sample width (signed two's complement).
- FIFO_DEPTH, 4, sample buffer depth; power of two, at least 2.
- OSR_WIDTH, 16, width of the runtime oversampling-ratio input.

Ports:
- i_clk  in  1  system clock.
- i_rst_n  in  1  asynchronous active-low reset.
- i_start  in  1  one-cycle start request.
- i_stop  in  1  one-cycle stop request; graceful drain.
- i_osr  in  OSR_WIDTH  clocks per sample; latched on start.
- i_s_valid  in  1  upstream sample valid.
- o_s_ready  out  1  FIFO can accept; high when not full and state is not DRAIN.
- i_s_data  in  DATA_WIDTH  upstream sample, signed.
- o_dac_en  out  1  modulator enable; high in RUN and DRAIN.
- o_dac_data  out  DATA_WIDTH  sample held for the modulator, signed.
- o_sample_tick  out  1  one-cycle pulse at each sample load.
- o_underflow  out  1  sticky underflow flag.
- o_busy  out  1  state is not IDLE.

Behaviour:
- Reset (asynchronous, i_rst_n=0): state IDLE, FIFO empty, divider 0, latched OSR 2, o_dac_data 0, o_dac_en 0, o_sample_tick 0, o_underflow 0, o_busy 0. o_s_ready is 1 once reset deasserts.
- Reset mid-operation: all state and FIFO contents are discarded immediately; the output is silent (o_dac_en 0, o_dac_data 0).
- FIFO push: on i_s_valid && o_s_ready at a clock edge. Pushes are accepted in IDLE (preload) and RUN, never in DRAIN.
- Push with a full FIFO is impossible because o_s_ready is low. Write and read pointers wrap modulo FIFO_DEPTH. Count width is clog2(FIFO_DEPTH)+1.
- States: IDLE, RUN, DRAIN.
- IDLE -> RUN when i_start=1 and i_stop=0. If both are asserted together, stop wins and the block stays IDLE.
- On the IDLE->RUN edge:
  - r_osr latches max(i_osr, 2).
  - Divider is cleared to 0.
  - o_underflow is cleared.
  - An immediate sample load happens (see below).
- Sample load (tick): occurs on the start edge, then whenever divider == r_osr-1 in RUN or DRAIN. On a tick the divider returns to 0; otherwise it increments. Consecutive ticks are exactly r_osr clocks apart.
- Registered outputs on a tick:
  - FIFO non-empty: pop the head into o_dac_data; o_sample_tick=1 the following cycle, aligned with the new o_dac_data.
  - FIFO empty in RUN: o_dac_data holds its last value, o_underflow is set (sticky until the next start), o_sample_tick=1.
- Push and pop in the same cycle are both honoured and the count is unchanged. Push into an empty FIFO on a tick edge still counts as underflow, because the pop sees the count before the edge; the pushed word is retained.
- RUN -> DRAIN on i_stop=1. i_start in RUN or DRAIN is ignored; i_stop in IDLE or DRAIN is ignored.
- DRAIN: ticks continue and pop the remaining samples. On a tick with the FIFO empty:
  - o_dac_data <= 0, state -> IDLE, o_dac_en <= 0.
  - No underflow is flagged and o_sample_tick is 0.
- o_dac_en and o_busy are registered and change on the same edge as the state.
- i_osr changes while running have no effect until the next start.

Test Plan:
- Preload 3 samples (100, -200, 300) in IDLE, start with i_osr=4 → loads at start+1, +5, +9 carry 100, -200, 300; o_sample_tick pulses match; no underflow.
- FIFO full: push 5 samples in IDLE with FIFO_DEPTH=4 → o_s_ready low after the 4th; the 5th is held off until the first tick frees a slot.
- Underflow: start with an empty FIFO and i_osr=8 → o_dac_data stays 0, o_underflow=1 from start+1; after a push of 1000, the next tick shows 1000 and o_underflow stays 1; a restart clears it.
- Drain: two samples buffered, i_stop in RUN → o_s_ready=0, both samples are played at r_osr spacing, then o_dac_data=0, o_dac_en=0, o_busy=0 on the following tick.
- Corner cases:
  - i_osr=0 → ticks every 2 clocks.
  - i_start and i_stop together in IDLE → stays IDLE.
  - i_osr changed from 4 to 16 mid-RUN → spacing stays 4.
- Async reset asserted mid-RUN, off the clock edge → outputs go to 0 immediately; the FIFO is empty after release; a fresh start behaves as in the first scenario.
